// File: rtl/branch_perf_monitor_if.sv
// Processor debug/event bus observed by branch_perf_monitor.
interface branch_perf_monitor_if #(
    parameter int unsigned PC_W = 32
);
    logic            branch_valid;
    logic [PC_W-1:0] debug_pc;
    logic            debug_misprediction;
    logic            debug_jump;

    modport master (
        output branch_valid,
        output debug_pc,
        output debug_misprediction,
        output debug_jump
    );

    modport slave (
        input branch_valid,
        input debug_pc,
        input debug_misprediction,
        input debug_jump
    );
endinterface

// File: rtl/branch_perf_monitor.sv
// Branch-prediction statistics with a hardware-limited measurement window.
// Define BPM_PC_LOG_EN to include the mispredicted-PC log FIFO.
module branch_perf_monitor #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned LOG_DEPTH   = 8,
    parameter int unsigned CYCLE_LIMIT = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    branch_perf_monitor_if.slave  dbg,
    input  logic                  log_rd_en,
    output logic [PC_W-1:0]       log_rd_data,
    output logic                  log_empty,
    output logic                  log_full,
    output logic                  log_overflow,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      mispred_count,
    output logic [CNT_W-1:0]      jump_count,
    output logic                  done
);
    typedef enum logic {ST_RUN, ST_DONE} state_t;

    localparam logic [CNT_W-1:0] LIMIT_LAST =
        CNT_W'((CYCLE_LIMIT == 0) ? 0 : CYCLE_LIMIT - 1);

    state_t state, state_nxt;
    logic   active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign active = enable && (state == ST_RUN);
    assign done   = (state == ST_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Window closes on the active cycle that takes cycle_count to CYCLE_LIMIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (active && (CYCLE_LIMIT != 0) && (cycle_count == LIMIT_LAST))
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_RUN;
        endcase
        if (clear) state_nxt = ST_RUN;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count   <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
            jump_count    <= '0;
        end else if (clear) begin
            cycle_count   <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
            jump_count    <= '0;
        end else if (active) begin
            cycle_count <= sat_inc(cycle_count);
            if (dbg.branch_valid)        branch_count  <= sat_inc(branch_count);
            if (dbg.debug_misprediction) mispred_count <= sat_inc(mispred_count);
            if (dbg.debug_jump)          jump_count    <= sat_inc(jump_count);
        end
    end

`ifdef BPM_PC_LOG_EN
    localparam int unsigned AW = $clog2(LOG_DEPTH);

    logic [PC_W-1:0] log_mem [LOG_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            push_req, do_push, do_pop;

    assign log_empty = (wr_ptr == rd_ptr);
    assign log_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req  = active && dbg.debug_misprediction;
    assign do_pop    = log_rd_en && !log_empty;
    // A same-cycle pop frees the slot, so a push into a full log still lands.
    assign do_push   = push_req && (!log_full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push_req && log_full && !do_pop) log_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) log_mem[wr_ptr[AW-1:0]] <= dbg.debug_pc;
    end

    assign log_rd_data = log_empty ? '0 : log_mem[rd_ptr[AW-1:0]];
`else
    logic unused_log;

    assign unused_log   = (^{log_rd_en, dbg.debug_pc}) ^ (LOG_DEPTH == 0);
    assign log_rd_data  = '0;
    assign log_empty    = 1'b1;
    assign log_full     = 1'b0;
    assign log_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_branch_perf_monitor.sv
// Directed self-checking bench for branch_perf_monitor (default and 4-bit counter instances).
module tb_branch_perf_monitor;
`ifdef BPM_PC_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    logic en_a, clr_a, rd_a;
    logic en_b, clr_b, rd_b;

    logic [31:0] a_rd_data, a_cyc, a_br, a_mp, a_jmp;
    logic        a_empty, a_full, a_ovf, a_done;
    logic [31:0] b_rd_data;
    logic [3:0]  b_cyc, b_br, b_mp, b_jmp;
    logic        b_empty, b_full, b_ovf, b_done;

    int checks   = 0;
    int failures = 0;

    branch_perf_monitor_if #(.PC_W(32)) bus ();

    branch_perf_monitor #(
        .PC_W(32), .CNT_W(32), .LOG_DEPTH(8), .CYCLE_LIMIT(25)
    ) u_dut (
        .clock(clock), .reset(reset), .enable(en_a), .clear(clr_a), .dbg(bus.slave),
        .log_rd_en(rd_a), .log_rd_data(a_rd_data), .log_empty(a_empty),
        .log_full(a_full), .log_overflow(a_ovf), .cycle_count(a_cyc),
        .branch_count(a_br), .mispred_count(a_mp), .jump_count(a_jmp), .done(a_done)
    );

    branch_perf_monitor #(
        .PC_W(32), .CNT_W(4), .LOG_DEPTH(8), .CYCLE_LIMIT(0)
    ) u_sat (
        .clock(clock), .reset(reset), .enable(en_b), .clear(clr_b), .dbg(bus.slave),
        .log_rd_en(rd_b), .log_rd_data(b_rd_data), .log_empty(b_empty),
        .log_full(b_full), .log_overflow(b_ovf), .cycle_count(b_cyc),
        .branch_count(b_br), .mispred_count(b_mp), .jump_count(b_jmp), .done(b_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_bus(input logic bv, input logic mp, input logic jmp, input logic [31:0] pc);
        bus.branch_valid        = bv;
        bus.debug_misprediction = mp;
        bus.debug_jump          = jmp;
        bus.debug_pc            = pc;
    endtask

    initial begin
        reset = 1'b0;
        en_a = 1'b0; clr_a = 1'b0; rd_a = 1'b0;
        en_b = 1'b0; clr_b = 1'b0; rd_b = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset values
        #12;
        check("rst_cycle", a_cyc, 0);
        check("rst_branch", a_br, 0);
        check("rst_mispred", a_mp, 0);
        check("rst_jump", a_jmp, 0);
        check("rst_done", a_done, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_b_cycle", b_cyc, 0);
        reset = 1'b1;
        step();

        // Window of 25 idle active cycles
        en_a = 1'b1;
        repeat (24) step();
        check("win_cycle24", a_cyc, 24);
        check("win_done24", a_done, 0);
        step();
        check("win_cycle25", a_cyc, 25);
        check("win_done25", a_done, 1);
        check("win_branch", a_br, 0);
        check("win_mispred", a_mp, 0);
        repeat (3) step();
        check("win_frozen", a_cyc, 25);
        check("win_done_hold", a_done, 1);
        en_a = 1'b0;

        // Clear after done, then three mispredicting branches
        clr_a = 1'b1; step(); clr_a = 1'b0;
        check("clr_cycle", a_cyc, 0);
        check("clr_done", a_done, 0);
        en_a = 1'b1;
        set_bus(1'b1, 1'b1, 1'b0, 32'h10); step();
        set_bus(1'b1, 1'b1, 1'b1, 32'h24); step();
        set_bus(1'b1, 1'b1, 1'b0, 32'h38); step();
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        en_a = 1'b0;
        check("mp3_branch", a_br, 3);
        check("mp3_mispred", a_mp, 3);
        check("mp3_jump", a_jmp, 1);
        check("mp3_cycle", a_cyc, 3);
        check("mp3_empty", a_empty, !LOG_EN);
        check("mp3_head0", a_rd_data, LOG_EN ? 32'h10 : 32'h0);
        rd_a = 1'b1;
        step(); check("mp3_head1", a_rd_data, LOG_EN ? 32'h24 : 32'h0);
        step(); check("mp3_head2", a_rd_data, LOG_EN ? 32'h38 : 32'h0);
        step(); rd_a = 1'b0;
        check("mp3_drained", a_empty, 1);
        check("mp3_drained_data", a_rd_data, 0);

        // Pop on empty is ignored while the same-cycle push proceeds
        en_a = 1'b1; rd_a = 1'b1;
        set_bus(1'b0, 1'b1, 1'b0, 32'h55); step();
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        en_a = 1'b0; rd_a = 1'b0;
        check("pope_empty", a_empty, !LOG_EN);
        check("pope_head", a_rd_data, LOG_EN ? 32'h55 : 32'h0);
        check("pope_mispred", a_mp, 4);

        // Fill exactly, then push+pop while full
        clr_a = 1'b1; step(); clr_a = 1'b0;
        check("fill_clr_empty", a_empty, 1);
        en_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_bus(1'b0, 1'b1, 1'b0, 32'h200 + 32'(4 * i));
            step();
        end
        check("fill_full", a_full, LOG_EN);
        check("fill_ovf", a_ovf, 0);
        check("fill_head", a_rd_data, LOG_EN ? 32'h200 : 32'h0);
        set_bus(1'b0, 1'b1, 1'b0, 32'h40);
        rd_a = 1'b1; step(); rd_a = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        en_a = 1'b0;
        check("pp_full", a_full, LOG_EN);
        check("pp_ovf", a_ovf, 0);
        check("pp_mispred", a_mp, 9);
        rd_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("pp_drain", a_rd_data,
                  !LOG_EN ? 32'h0 : (i < 7 ? 32'h204 + 32'(4 * i) : 32'h40));
            step();
        end
        rd_a = 1'b0;
        check("pp_drained", a_empty, 1);

        // Overflow: 10 mispredictions, no pops
        clr_a = 1'b1; step(); clr_a = 1'b0;
        en_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_bus(1'b0, 1'b1, 1'b0, 32'h100 + 32'(4 * i));
            step();
        end
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        en_a = 1'b0;
        check("ovf_mispred", a_mp, 10);
        check("ovf_cycle", a_cyc, 10);
        check("ovf_full", a_full, LOG_EN);
        check("ovf_flag", a_ovf, LOG_EN);
        rd_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", a_rd_data, LOG_EN ? 32'h100 + 32'(4 * i) : 32'h0);
            step();
        end
        rd_a = 1'b0;
        check("ovf_drained", a_empty, 1);
        check("ovf_flag_sticky", a_ovf, LOG_EN);

        // 4-bit counters saturate, then clear beats a same-cycle event
        en_b = 1'b1;
        set_bus(1'b1, 1'b1, 1'b1, 32'h77);
        repeat (20) step();
        check("sat_cycle", b_cyc, 15);
        check("sat_branch", b_br, 15);
        check("sat_mispred", b_mp, 15);
        check("sat_jump", b_jmp, 15);
        check("sat_nolimit_done", b_done, 0);
        check("sat_full", b_full, LOG_EN);
        check("sat_ovf", b_ovf, LOG_EN);
        clr_b = 1'b1; step(); clr_b = 1'b0;
        en_b = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        check("sclr_cycle", b_cyc, 0);
        check("sclr_branch", b_br, 0);
        check("sclr_mispred", b_mp, 0);
        check("sclr_jump", b_jmp, 0);
        check("sclr_empty", b_empty, 1);
        check("sclr_full", b_full, 0);
        check("sclr_ovf", b_ovf, 0);
        check("sclr_rd_data", b_rd_data, 0);

        // Asynchronous reset mid-window
        clr_a = 1'b1; step(); clr_a = 1'b0;
        set_bus(1'b0, 1'b1, 1'b0, 32'h99);
        en_a = 1'b1;
        repeat (12) step();
        check("mid_cycle12", a_cyc, 12);
        check("mid_mispred12", a_mp, 12);
        #2 reset = 1'b0;
        #1;
        check("arst_cycle", a_cyc, 0);
        check("arst_mispred", a_mp, 0);
        check("arst_empty", a_empty, 1);
        check("arst_ovf", a_ovf, 0);
        check("arst_rd_data", a_rd_data, 0);
        #2 reset = 1'b1;
        set_bus(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (24) step();
        check("post_cycle24", a_cyc, 24);
        check("post_done24", a_done, 0);
        step();
        check("post_cycle25", a_cyc, 25);
        check("post_done25", a_done, 1);
        en_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_perf_monitor.md
# branch_perf_monitor

Parametrised branch-prediction performance monitor that sits beside `PROCESSOR` and consumes its `debug_pc`, `debug_misprediction` and `debug_jump` outputs. Counts cycles, resolved branches, mispredictions and jumps in saturating counters, and logs each mispredicting PC into a first-word-fall-through FIFO for later readout. A programmable cycle limit freezes all statistics and raises `done`, so the measurement window is fixed in hardware rather than by simulation time.

## Interface
- `PC_W`, 32, width of logged PC
- `CNT_W`, 32, width of every statistics counter
- `LOG_DEPTH`, 8, misprediction log entries; power of two, ≥2
- `CYCLE_LIMIT`, 25, enabled cycles in the measurement window; 0 = unlimited; must fit in `CNT_W`
- `clock` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low; asserting it (low) clears all state immediately
- `enable` input 1 — counting/logging permitted this cycle
- `clear` input 1 — synchronous clear of counters, log, `done`, `log_overflow`
- `branch_valid` input 1 — a conditional branch resolved this cycle
- `debug_pc` input PC_W — PC associated with this cycle's events
- `debug_misprediction` input 1 — misprediction detected this cycle
- `debug_jump` input 1 — jump taken this cycle
- `log_rd_en` input 1 — pop head of log
- `log_rd_data` output PC_W — head of log (valid when `log_empty`=0)
- `log_empty` output 1, `log_full` output 1 — log status
- `log_overflow` output 1 — sticky: a misprediction was dropped because the log was full
- `cycle_count`, `branch_count`, `mispred_count`, `jump_count` outputs CNT_W each
- `done` output 1 — measurement window closed

## Operation
- Active cycle = `enable`=1 and `done`=0. Only active cycles change counters or push the log.
- `cycle_count` +1 per active cycle; `branch_count` +1 on `branch_valid`; `mispred_count` +1 on `debug_misprediction`; `jump_count` +1 on `debug_jump`. All independent; all may increment in the same cycle.
- Counters saturate at 2^CNT_W−1; no wrap.
- `done` sets on the active cycle in which `cycle_count` goes from CYCLE_LIMIT−1 to CYCLE_LIMIT; events in that cycle are counted. `done` stays set until `clear` or reset. CYCLE_LIMIT=0: `done` never sets.
- Log push: active cycle with `debug_misprediction`=1 writes `debug_pc`. If full and no pop same cycle: entry dropped, `log_overflow` set, `mispred_count` still increments.
- Log pop: `log_rd_en`=1 and `log_empty`=0 advances head; pop on empty ignored. Pops allowed while `done`=1 or `enable`=0.
- Push and pop same cycle: both succeed, including when full (occupancy unchanged) and when empty-then-pushed is not applicable (pop on empty ignored, push proceeds).
- `clear` has priority over all same-cycle events: everything returns to reset values, event discarded.

## Timing
- Reset values: all counters 0, `done`=0, `log_empty`=1, `log_full`=0, `log_overflow`=0, `log_rd_data`=0.
- Counters, `done`, status flags registered: change visible the cycle after the causing edge (1-cycle latency).
- `log_rd_data` is the head entry combinationally from registered storage; valid the cycle after the first push.
- `log_full` asserted when occupancy = LOG_DEPTH; pointers wrap modulo LOG_DEPTH with an extra occupancy bit to distinguish full/empty.
- Reset asserted mid-window: all state cleared asynchronously; monitoring restarts on first active cycle after release.

## Configuration
- `BPM_PC_LOG_EN` defined: log FIFO present as described.
- Not defined: no log storage; `log_rd_data`=0, `log_empty`=1, `log_full`=0, `log_overflow`=0 constant; `log_rd_en` ignored; all counters and `done` unchanged.

## Test plan
- Reset low, release, `enable`=1 for 25 cycles with no events → `cycle_count`=25, `done`=1, other counters 0; further cycles leave `cycle_count`=25.
- Mispredictions at PCs 0x10, 0x24, 0x38 with `branch_valid`=1 → `branch_count`=3, `mispred_count`=3; three pops return 0x10, 0x24, 0x38 then `log_empty`=1.
- 10 mispredictions with LOG_DEPTH=8, no pops → `log_full`=1, `log_overflow`=1, `mispred_count`=10, log holds first 8 PCs.
- Full log, simultaneous push 0x40 and pop → occupancy stays 8, `log_full`=1, `log_overflow`=0, 0x40 becomes tail.
- `clear` asserted same cycle as misprediction with CNT_W=4 after counters saturated at 15 → all counters 0, log empty, `done`=0.
- `reset` pulsed low mid-window at `cycle_count`=12 → outputs at reset values immediately; `done` reached 25 active cycles after release.
